// File: rtl/mul_operand_serializer.sv
// Parallel-to-serial operand feeder for the bit-serial multiplier: a small FIFO
// of operand pairs drained into LSB-first frames aligned to a free-running bit counter.
module mul_operand_serializer #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  input  logic [WIDTH-1:0]         IN_A,
  input  logic [WIDTH-1:0]         IN_B,
  output logic                     A,
  output logic                     B,
  output logic                     SYNC,
  output logic                     FRAME_VALID,
  output logic [$clog2(DEPTH):0]   COUNT
);

  localparam int IW = $clog2(WIDTH);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [IW-1:0]    bit_idx_r;
  logic [WIDTH-1:0] sh_a_r;
  logic [WIDTH-1:0] sh_b_r;
  logic             frame_valid_r;
  logic [WIDTH-1:0] mem_a_r [DEPTH];
  logic [WIDTH-1:0] mem_b_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;

  logic             full_s;
  logic             load_s;
  logic             push_s;
  logic             pop_s;
  logic [CW-1:0]    count_nxt_s;
  logic [WIDTH-1:0] sh_a_nxt_s;
  logic [WIDTH-1:0] sh_b_nxt_s;
  logic             frame_valid_nxt_s;

  // Handshake, load decision and next-state of the shifters and occupancy.
  always_comb begin
    full_s            = (count_r >= CW'(DEPTH));
    load_s            = (bit_idx_r == IW'(WIDTH - 1));
    push_s            = IN_VALID && !full_s;
    pop_s             = load_s && (count_r != '0);
    count_nxt_s       = count_r;
    sh_a_nxt_s        = {1'b0, sh_a_r[WIDTH-1:1]};
    sh_b_nxt_s        = {1'b0, sh_b_r[WIDTH-1:1]};
    frame_valid_nxt_s = frame_valid_r;

    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase

    // The head is read before any same-edge push lands, so there is no bypass.
    if (load_s) begin
      if (pop_s) begin
        sh_a_nxt_s        = mem_a_r[rd_ptr_r];
        sh_b_nxt_s        = mem_b_r[rd_ptr_r];
        frame_valid_nxt_s = 1'b1;
      end else begin
        sh_a_nxt_s        = '0;
        sh_b_nxt_s        = '0;
        frame_valid_nxt_s = 1'b0;
      end
    end else begin
      frame_valid_nxt_s = frame_valid_r;
    end
  end

  // Control and datapath registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      bit_idx_r     <= '0;
      sh_a_r        <= '0;
      sh_b_r        <= '0;
      frame_valid_r <= 1'b0;
      wr_ptr_r      <= '0;
      rd_ptr_r      <= '0;
      count_r       <= '0;
    end else begin
      bit_idx_r     <= bit_idx_r + IW'(1);
      sh_a_r        <= sh_a_nxt_s;
      sh_b_r        <= sh_b_nxt_s;
      frame_valid_r <= frame_valid_nxt_s;
      count_r       <= count_nxt_s;
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
    end
  end

  // FIFO storage; contents are only meaningful between push and pop.
  always_ff @(posedge CLK) begin
    if (RST && push_s) begin
      mem_a_r[wr_ptr_r] <= IN_A;
      mem_b_r[wr_ptr_r] <= IN_B;
    end
  end

  assign IN_READY    = !full_s;
  assign A           = sh_a_r[0];
  assign B           = sh_b_r[0];
  assign SYNC        = (bit_idx_r == '0);
  assign FRAME_VALID = frame_valid_r;
  assign COUNT       = count_r;

endmodule
